cpu_term_sync: RTL and testbench
================================

# cpu_term_sync

Bus-cycle termination front end for the CPU state machine. Synchronises the raw 68030 DSACK1_/DSACK0_ and STERM_ inputs, qualifies them against the active cycle, latches the port size, and enforces a bus timeout. It then presents the complementary registered termination pairs DSACK/nDSACK and STERM_/nSTERM_ that the per-bit next-state logic of the CPU state machine consumes.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth for DSACK1_/DSACK0_; legal range is 2 or more.
- TIMEOUT, 255: cycles in WAIT before a forced timeout; legal range is 1 or more.
- TO_W, 8: counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  in  1  state-machine clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- CYC_ACTIVE  in  1  high while the CPU state machine owns a bus cycle.
- DSACK0_  in  1  raw bus DSACK0, active-low, asynchronous.
- DSACK1_  in  1  raw bus DSACK1, active-low, asynchronous.
- STERM_IN_  in  1  raw bus STERM, active-low, synchronous to CLK.
- DSACK  out  1  qualified asynchronous termination; 1 = acknowledged.
- nDSACK  out  1  always the complement of DSACK.
- STERM_  out  1  qualified synchronous termination; 0 = terminated.
- nSTERM_  out  1  always the complement of STERM_.
- SIZE  out  2  latched port size: 00 none, 01 byte, 10 word, 11 long.
- TIMEOUT_ERR  out  1  cycle terminated by timeout.

## Operation
Reset values:
- DSACK=0, nDSACK=1, STERM_=1, nSTERM_=0, SIZE=00, TIMEOUT_ERR=0.
- Every synchroniser flop and the compare register reset to 1 (negated). The counter resets to 0. State is IDLE.

Datapath:
- DSACK1_/DSACK0_ pass through SYNC_STAGES flops (s1..sN), followed by a compare register sC that holds the previous sN.
- The DSACK pair is stable when sN == sC and sN != 11.
- STERM_IN_ is registered once (stR) with no synchroniser.
- Size decode from the stable sN (DSACK1_,DSACK0_): 10 gives byte (01), 01 gives word (10), 00 gives long (11).

States:
- IDLE
  - CYC_ACTIVE=1 goes to WAIT; counter cleared to 0.
- WAIT (checked in priority order at each edge)
  - CYC_ACTIVE=0 (aborted cycle) goes to HOLD; no outputs change.
  - stR=0, or STERM_IN_=0 at this edge: set STERM_=0 and SIZE=11, go to TERM. STERM wins over a simultaneous stable DSACK, and DSACK stays 0.
  - DSACK pair stable: set DSACK=1, SIZE=decoded size, go to TERM.
  - counter == TIMEOUT-1: set TIMEOUT_ERR=1, SIZE=00, go to TERM.
  - Otherwise the counter increments. It saturates and never wraps.
- TERM
  - Outputs hold their levels.
  - CYC_ACTIVE=0: DSACK=0, STERM_=1, TIMEOUT_ERR=0, go to HOLD. SIZE holds until the next WAIT entry.
- HOLD
  - Waits for bus negation. sN==11 and stR=1 go to IDLE.
  - A new CYC_ACTIVE during HOLD is not acted on until IDLE is reached, so stale acknowledges cannot terminate the next cycle.

Other rules:
- In IDLE and HOLD no termination output is ever asserted.
- RST asserted in any state forces all reset values at that edge, and the synchronisers are flushed.
- The complement pairs are driven from the same registers, so they can never be equal.

## Timing
- Taking edge k as the first edge that samples raw DSACKx_ low (steady), DSACK=1 is visible after edge k+SYNC_STAGES+1. With the default, that is after k+3. Minimum latency is 3 edges.
- A DSACK0_/DSACK1_ skew of one cycle delays qualification by one further edge. SIZE always reflects the final stable pair.
- STERM_IN_ low sampled at edge k while in WAIT makes STERM_=0 visible after edge k, giving 1-edge latency.
- Timeout: entering WAIT at edge e with no termination makes TIMEOUT_ERR=1 after edge e+TIMEOUT.
- CYC_ACTIVE falling at edge f in TERM makes DSACK/STERM_/TIMEOUT_ERR negate after edge f.
- HOLD to IDLE takes at least one edge. The earliest re-entry to WAIT is the edge after reaching IDLE.

## Test plan
- Reset, then CYC_ACTIVE=1 and DSACK1_=0/DSACK0_=0 from edge k: DSACK=1, nDSACK=0, SIZE=11 after edge k+3. CYC_ACTIVE=0 at edge f: DSACK=0 after f. Negating the acks returns the block to IDLE.
- DSACK1_=1, DSACK0_=0: SIZE=01. Separately, DSACK0_ falling one cycle after DSACK1_: no DSACK while the pair reads 01, then DSACK=1 with SIZE=11 once 00 is stable for two samples.
- STERM_IN_=0 and both DSACKs low together at edge k: STERM_=0, nSTERM_=1 after k; DSACK stays 0; SIZE=11.
- TIMEOUT=4, CYC_ACTIVE=1 with no acks: TIMEOUT_ERR=1 after the 4th edge in WAIT; DSACK=0 and STERM_=1 throughout.
- Acks held low after CYC_ACTIVE drops, then a new CYC_ACTIVE=1: the block stays in HOLD and no DSACK is asserted until the acks negate and a fresh qualification completes.
- RST=1 for one cycle while in TERM with DSACK=1: all outputs return to reset values after that edge and the state is IDLE.

Source files
------------

// File: rtl/cpu_term_sync.sv
// Bus-cycle termination front end: synchronises DSACKx_/STERM_, qualifies them
// against the active cycle, latches port size and enforces a bus timeout.
module cpu_term_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CYC_ACTIVE,
  input  logic       DSACK0_,
  input  logic       DSACK1_,
  input  logic       STERM_IN_,
  output logic       DSACK,
  output logic       nDSACK,
  output logic       STERM_,
  output logic       nSTERM_,
  output logic [1:0] SIZE,
  output logic       TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TERM = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] LP_CNT_MAX = '1;

  logic [1:0]      r_sync [SYNC_STAGES];
  logic [1:0]      r_cmp;
  logic            r_stR;
  state_t          r_state;
  logic [TO_W-1:0] r_cnt;
  logic            r_dsack;
  logic            r_sterm;
  logic [1:0]      r_size;
  logic            r_toErr;

  state_t          w_stateNxt;
  logic [TO_W-1:0] w_cntNxt;
  logic            w_dsackNxt;
  logic            w_stermNxt;
  logic [1:0]      w_sizeNxt;
  logic            w_toErrNxt;
  logic [1:0]      w_sN;
  logic            w_stable;
  logic            w_stermReq;
  logic [1:0]      w_sizeDec;

  // Pair is {DSACK1_, DSACK0_}; all stages idle at negated (11).
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 2'b11;
      r_cmp <= 2'b11;
      r_stR <= 1'b1;
    end else begin
      r_sync[0] <= {DSACK1_, DSACK0_};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_cmp <= r_sync[SYNC_STAGES-1];
      r_stR <= STERM_IN_;
    end
  end

  assign w_sN       = r_sync[SYNC_STAGES-1];
  assign w_stable   = (w_sN == r_cmp) && (w_sN != 2'b11);
  assign w_stermReq = !r_stR || !STERM_IN_;

  always_comb begin
    w_sizeDec = 2'b00;
    case (w_sN)
      2'b10:   w_sizeDec = 2'b01;
      2'b01:   w_sizeDec = 2'b10;
      2'b00:   w_sizeDec = 2'b11;
      default: w_sizeDec = 2'b00;
    endcase
  end

  always_comb begin
    w_stateNxt = r_state;
    w_cntNxt   = r_cnt;
    w_dsackNxt = r_dsack;
    w_stermNxt = r_sterm;
    w_sizeNxt  = r_size;
    w_toErrNxt = r_toErr;
    case (r_state)
      ST_IDLE: begin
        if (CYC_ACTIVE) begin
          w_stateNxt = ST_WAIT;
          w_cntNxt   = '0;
          w_sizeNxt  = 2'b00;
        end
      end
      // Priority: abort, STERM, stable DSACK, timeout, count.
      ST_WAIT: begin
        if (!CYC_ACTIVE) begin
          w_stateNxt = ST_HOLD;
        end else if (w_stermReq) begin
          w_stermNxt = 1'b0;
          w_sizeNxt  = 2'b11;
          w_stateNxt = ST_TERM;
        end else if (w_stable) begin
          w_dsackNxt = 1'b1;
          w_sizeNxt  = w_sizeDec;
          w_stateNxt = ST_TERM;
        end else if (r_cnt == LP_TO_LAST) begin
          w_toErrNxt = 1'b1;
          w_sizeNxt  = 2'b00;
          w_stateNxt = ST_TERM;
        end else if (r_cnt != LP_CNT_MAX) begin
          w_cntNxt = r_cnt + TO_W'(1);
        end
      end
      ST_TERM: begin
        if (!CYC_ACTIVE) begin
          w_dsackNxt = 1'b0;
          w_stermNxt = 1'b1;
          w_toErrNxt = 1'b0;
          w_stateNxt = ST_HOLD;
        end
      end
      // Stale acknowledges must clear before a new cycle is accepted.
      ST_HOLD: begin
        if ((w_sN == 2'b11) && r_stR) w_stateNxt = ST_IDLE;
      end
      default: w_stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dsack <= 1'b0;
      r_sterm <= 1'b1;
      r_size  <= 2'b00;
      r_toErr <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      r_cnt   <= w_cntNxt;
      r_dsack <= w_dsackNxt;
      r_sterm <= w_stermNxt;
      r_size  <= w_sizeNxt;
      r_toErr <= w_toErrNxt;
    end
  end

  assign DSACK       = r_dsack;
  assign nDSACK      = ~r_dsack;
  assign STERM_      = r_sterm;
  assign nSTERM_     = ~r_sterm;
  assign SIZE        = r_size;
  assign TIMEOUT_ERR = r_toErr;

endmodule

// File: tb/tb_cpu_term_sync.sv
// Directed bench for cpu_term_sync: expected terminations are queued with their
// edge number and checked by an independent monitor on the falling clock edge.
module tb_cpu_term_sync;

  logic       CLK;
  logic       RST;
  logic       CYC_ACTIVE;
  logic       DSACK0_;
  logic       DSACK1_;
  logic       STERM_IN_;
  logic       DSACK;
  logic       nDSACK;
  logic       STERM_;
  logic       nSTERM_;
  logic [1:0] SIZE;
  logic       TIMEOUT_ERR;

  typedef struct packed {
    logic       dsack;
    logic       sterm;
    logic [1:0] size;
    logic       toErr;
    int         edgeNo;
    int         id;
  } termExp_t;

  termExp_t sbQ[$];
  int assertions = 0;
  int failures   = 0;
  int edgeCount  = 0;
  int nextId     = 0;
  bit monitorOn  = 0;
  bit prevTerm   = 0;

  cpu_term_sync #(.SYNC_STAGES(2), .TIMEOUT(4), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST), .CYC_ACTIVE(CYC_ACTIVE),
    .DSACK0_(DSACK0_), .DSACK1_(DSACK1_), .STERM_IN_(STERM_IN_),
    .DSACK(DSACK), .nDSACK(nDSACK), .STERM_(STERM_), .nSTERM_(nSTERM_),
    .SIZE(SIZE), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) edgeCount <= edgeCount + 1;

  // Monitor: complement pairs every cycle, and each new termination against the queue.
  always @(negedge CLK) begin
    if (monitorOn && !RST) begin
      logic wTerm;
      termExp_t e;
      assertions++;
      if (nDSACK !== ~DSACK || nSTERM_ !== ~STERM_) begin
        failures++;
        $display("[TB] FAIL complement edge %0d: DSACK=%b nDSACK=%b STERM_=%b nSTERM_=%b, required opposite levels",
                 edgeCount, DSACK, nDSACK, STERM_, nSTERM_);
      end
      wTerm = DSACK | ~STERM_ | TIMEOUT_ERR;
      if (wTerm && !prevTerm) begin
        assertions++;
        if (sbQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpectedTerm edge %0d: DSACK=%b STERM_=%b SIZE=%b TIMEOUT_ERR=%b, required no termination",
                   edgeCount, DSACK, STERM_, SIZE, TIMEOUT_ERR);
        end else begin
          e = sbQ.pop_front();
          if (DSACK !== e.dsack || STERM_ !== e.sterm || SIZE !== e.size ||
              TIMEOUT_ERR !== e.toErr || edgeCount != e.edgeNo) begin
            failures++;
            $display("[TB] FAIL term#%0d: got edge %0d DSACK=%b STERM_=%b SIZE=%b TO=%b, required edge %0d DSACK=%b STERM_=%b SIZE=%b TO=%b",
                     e.id, edgeCount, DSACK, STERM_, SIZE, TIMEOUT_ERR,
                     e.edgeNo, e.dsack, e.sterm, e.size, e.toErr);
          end
        end
      end
      prevTerm = wTerm;
    end else begin
      prevTerm = 1'b0;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic cyc, input logic d1, input logic d0, input logic st);
    CYC_ACTIVE = cyc;
    DSACK1_    = d1;
    DSACK0_    = d0;
    STERM_IN_  = st;
  endtask

  task automatic expectTerm(input logic d, input logic s, input logic [1:0] sz,
                            input logic t, input int edgeNo);
    termExp_t e;
    e.dsack  = d;
    e.sterm  = s;
    e.size   = sz;
    e.toErr  = t;
    e.edgeNo = edgeNo;
    e.id     = nextId;
    nextId++;
    sbQ.push_back(e);
  endtask

  // Vector order: DSACK, nDSACK, STERM_, nSTERM_, SIZE[1:0], TIMEOUT_ERR.
  task automatic checkOutput(input string name, input logic [6:0] req);
    logic [6:0] act;
    act = {DSACK, nDSACK, STERM_, nSTERM_, SIZE, TIMEOUT_ERR};
    assertions++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic checkDrained(input string name);
    assertions++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s: %0d expected terminations never seen, required 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  initial begin
    int k;
    RST = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(3);
    RST = 1'b0;
    tick(1);
    monitorOn = 1'b1;
    checkOutput("reset", 7'b0_1_1_0_00_0);

    $display("[TB] long port DSACK");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    k = edgeCount + 1;
    expectTerm(1'b1, 1'b1, 2'b11, 1'b0, k + 3);
    tick(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("longDrop", 7'b0_1_1_0_11_0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(4);
    checkDrained("longDrained");

    $display("[TB] byte port DSACK");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    k = edgeCount + 1;
    expectTerm(1'b1, 1'b1, 2'b01, 1'b0, k + 3);
    tick(5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("byteDrop", 7'b0_1_1_0_01_0);
    tick(4);
    checkDrained("byteDrained");

    $display("[TB] skewed DSACK0_");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    k = edgeCount + 1;
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    expectTerm(1'b1, 1'b1, 2'b11, 1'b0, k + 4);
    tick(5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("skewDrop", 7'b0_1_1_0_11_0);
    tick(4);
    checkDrained("skewDrained");

    $display("[TB] STERM with simultaneous DSACK");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    k = edgeCount + 1;
    expectTerm(1'b0, 1'b0, 2'b11, 1'b0, k);
    tick(5);
    checkOutput("stermHold", 7'b0_1_0_1_11_0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("stermDrop", 7'b0_1_1_0_11_0);
    tick(4);
    checkDrained("stermDrained");

    $display("[TB] timeout");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    k = edgeCount + 1;
    expectTerm(1'b0, 1'b1, 2'b00, 1'b1, k + 4);
    tick(7);
    checkOutput("toHold", 7'b0_1_1_0_00_1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("toDrop", 7'b0_1_1_0_00_0);
    tick(3);
    checkDrained("toDrained");

    $display("[TB] stale acknowledge held through HOLD");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    k = edgeCount + 1;
    expectTerm(1'b1, 1'b1, 2'b11, 1'b0, k + 3);
    tick(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(6);
    checkOutput("staleHold", 7'b0_1_1_0_11_0);
    checkDrained("staleFirst");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    k = edgeCount + 1;
    expectTerm(1'b1, 1'b1, 2'b11, 1'b0, k + 3);
    tick(5);
    checkDrained("staleFresh");
    checkOutput("freshTerm", 7'b1_0_1_0_11_0);

    $display("[TB] reset while terminated");
    RST = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    RST = 1'b0;
    checkOutput("rstTerm", 7'b0_1_1_0_00_0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    k = edgeCount + 1;
    expectTerm(1'b1, 1'b1, 2'b11, 1'b0, k + 3);
    tick(5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("postRstDrop", 7'b0_1_1_0_11_0);
    tick(4);
    checkDrained("postRstDrained");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
